// File: rtl/wb_pkg.sv
// Shared widths and payload types for the register-file writeback path.
package wb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t r);
        return NREG'(1) << r;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small FIFO holding load results until the register file write port is free.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2,
    localparam int unsigned PW = $clog2(LQ_DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    output wb_entry_t     head_c,
    output logic          empty_c,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [LQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];
    assign do_push = push && (count < CW'(LQ_DEPTH));
    assign do_pop  = pop && !empty_c;

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because LQ_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Register-file write-port owner: ALU-first arbitration against buffered loads,
// plus a busy scoreboard of registers with outstanding loads.
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2,
    localparam int unsigned CW = $clog2(LQ_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_write,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_data,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   lq_count
);

    logic            push;
    logic            pop;
    wb_entry_t       push_entry;
    wb_entry_t       head_c;
    logic            empty_c;
    logic [NREG-1:0] busy_next;

    // Acceptance looks only at registered occupancy, never at a same-cycle pop.
    assign ld_ready   = (lq_count < CW'(LQ_DEPTH));
    assign push       = ld_valid && ld_ready;
    assign pop        = !alu_valid && !empty_c;
    assign push_entry = {ld_rd, ld_data};

    wb_load_fifo #(
        .LQ_DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_c     (head_c),
        .empty_c    (empty_c),
        .count      (lq_count)
    );

    // A new issue to the same register outranks the retiring load's clear.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next = busy_next & ~reg_onehot(head_c.rd);
        end
        if (ld_issue) begin
            busy_next = busy_next | reg_onehot(ld_issue_rd);
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Write port: ALU wins, otherwise drain the load FIFO; x0 never writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_write <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
        end else if (alu_valid) begin
            rf_write <= (alu_rd != '0);
            rf_addr  <= alu_rd;
            rf_data  <= alu_data;
        end else if (pop) begin
            rf_write <= (head_c.rd != '0);
            rf_addr  <= head_c.rd;
            rf_data  <= head_c.data;
        end else begin
            rf_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: a reference model predicts commits,
// busy and FIFO occupancy; predicted commits are queued and matched on rf_*.
module tb_wb_commit_unit;
    import wb_pkg::*;

    localparam int unsigned LQ_DEPTH = 2;
    localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_issue;
    logic [AW-1:0]   ld_issue_rd;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            rf_write;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_data;
    logic [NREG-1:0] busy;
    logic [CW-1:0]   lq_count;

    wb_commit_unit #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .rf_write    (rf_write),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .busy        (busy),
        .lq_count    (lq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    wb_entry_t       exp_q[$];
    wb_entry_t       m_lq[$];
    logic [NREG-1:0] m_busy;
    logic            m_accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_issue    = 1'b0;
        ld_issue_rd = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
    endtask

    // Advance one clock: update the model from current inputs, then compare.
    task automatic step();
        wb_entry_t e;
        logic      exp_w;
        logic      ready;
        exp_w      = 1'b0;
        ready      = (m_lq.size() < LQ_DEPTH);
        m_accepted = ld_valid && ready;
        if (alu_valid) begin
            if (alu_rd != '0) begin
                e.rd   = alu_rd;
                e.data = alu_data;
                exp_q.push_back(e);
                exp_w = 1'b1;
            end
        end else if (m_lq.size() > 0) begin
            e = m_lq.pop_front();
            m_busy[e.rd] = 1'b0;
            if (e.rd != '0) begin
                exp_q.push_back(e);
                exp_w = 1'b1;
            end
        end
        if (m_accepted) begin
            e.rd   = ld_rd;
            e.data = ld_data;
            m_lq.push_back(e);
        end
        if (ld_issue && ld_issue_rd != '0) begin
            m_busy[ld_issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rf_write", 32'(rf_write), 32'(exp_w));
        if (rf_write) begin
            if (exp_q.size() == 0) begin
                check("spurious_commit", 32'(rf_write), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rf_addr", 32'(rf_addr), 32'(e.rd));
                check("rf_data", rf_data, e.data);
            end
        end
        check("busy", busy, m_busy);
        check("lq_count", 32'(lq_count), 32'(m_lq.size()));
        check("ld_ready", 32'(ld_ready), 32'(m_lq.size() < LQ_DEPTH));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rf_write"}, 32'(rf_write), 32'd0);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_lq_count"}, 32'(lq_count), 32'd0);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] lrd [3];
        int li;
        lrd[0] = 5'd8;
        lrd[1] = 5'd9;
        lrd[2] = 5'd10;
        m_busy = '0;

        // Reset hold with random inputs.
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            alu_valid   = 1'($urandom);
            alu_rd      = AW'($urandom);
            alu_data    = $urandom;
            ld_issue    = 1'($urandom);
            ld_issue_rd = AW'($urandom);
            ld_valid    = 1'($urandom);
            ld_rd       = AW'($urandom);
            ld_data     = $urandom;
            @(posedge clk);
            #1;
            check_reset_state("rst_hold");
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        step();

        // ALU commit, then an x0 commit that must not write.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        step();
        check("alu_rd5_write", 32'(rf_write), 32'd1);
        check("alu_rd5_data", rf_data, 32'hDEAD_BEEF);
        alu_rd = 5'd0; alu_data = 32'h0000_1234;
        step();
        check("alu_x0_nowrite", 32'(rf_write), 32'd0);
        idle_inputs();

        // Load with scoreboard.
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        step();
        check("busy7_set", 32'(busy[7]), 32'd1);
        idle_inputs();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA5A5_A5A5;
        step();
        idle_inputs();
        step();
        check("ld7_write", 32'(rf_write), 32'd1);
        check("ld7_data", rf_data, 32'hA5A5_A5A5);
        check("busy7_clear", 32'(busy[7]), 32'd0);

        // Contention: ALU holds the port while loads 8,9,10 arrive.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            ld_issue = 1'b1; ld_issue_rd = lrd[i];
            step();
        end
        li = 0;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            alu_valid = (c < 4);
            alu_rd    = AW'(c + 1);
            alu_data  = 32'h1000 + 32'(c);
            ld_valid  = (li < 3);
            ld_rd     = (li < 3) ? lrd[li] : '0;
            ld_data   = 32'hC000_0000 + 32'(li);
            step();
            if (m_accepted) li++;
            if (c == 2) begin
                check("fill_count", 32'(lq_count), 32'd2);
                check("fill_ready", 32'(ld_ready), 32'd0);
                check("ld10_stalled", 32'(li), 32'd2);
            end
        end
        check("drain_count", 32'(lq_count), 32'd0);
        check("drain_busy", busy, 32'd0);

        // Set/clear race on x12.
        idle_inputs();
        ld_issue = 1'b1; ld_issue_rd = 5'd12;
        step();
        idle_inputs();
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0000_0C0C;
        step();
        idle_inputs();
        ld_issue = 1'b1; ld_issue_rd = 5'd12;
        step();
        check("race_busy12", 32'(busy[12]), 32'd1);
        check("race_write12", 32'(rf_write), 32'd1);
        check("race_addr12", 32'(rf_addr), 32'd12);
        idle_inputs();
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0000_0D0D;
        step();
        idle_inputs();
        step();
        check("race_busy12_clear", 32'(busy[12]), 32'd0);

        // Mid-operation asynchronous reset with a full FIFO.
        ld_issue = 1'b1; ld_issue_rd = 5'd8;
        step();
        ld_issue_rd = 5'd9;
        step();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_1111;
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h8888_8888;
        step();
        alu_rd = 5'd2; alu_data = 32'h2222_2222;
        ld_rd = 5'd9; ld_data = 32'h9999_9999;
        step();
        check("pre_rst_busy", busy, 32'h0000_0300);
        check("pre_rst_count", 32'(lq_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("mid_rst");
        m_lq.delete();
        exp_q.delete();
        m_busy = '0;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("post_rst_nowrite", 32'(rf_write), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
